pixel_scanner: RTL

Raster scan master for the 320x240 monochrome game screens. It drives the `VGAx`/`VGAy` pixel query into a game module, captures the returned 1-bit `VGAcol` after the game module's fixed pipeline delay, and emits framebuffer plot writes with `PlotX`, `PlotY` and a 3-bit colour. It sits between each game module and the VGA adapter's write port and sequences one full frame per `Start` request.

---
 rtl/pixel_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pixel_scanner.sv
// pixel_scanner: raster scan master; queries a game module pixel by pixel
// and emits one framebuffer plot per clock for each Start in IDLE.
//
// Ports:
//   Clock, Reset      : system clock, async active-high reset
//   Start, Abort      : begin one frame (IDLE only) / cancel a scan
//   VGAcol            : pixel colour returned by the game module
//   VGAx, VGAy        : queried coordinate (registered)
//   PlotX, PlotY      : framebuffer write coordinate (registered)
//   PlotCol, Plot     : write colour and write strobe (registered)
//   Busy, Done        : scan in progress / final plot of a frame
//   FrameCount        : completed frames, mod 256
module pixel_scanner #(
   parameter int         XMAX = 320,
   parameter int         YMAX = 240,
   parameter int         PIPE = 2,
   parameter logic [2:0] FG   = 3'b111,
   parameter logic [2:0] BG   = 3'b000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Abort,
   input  logic       VGAcol,
   output logic [8:0] VGAx,
   output logic [7:0] VGAy,
   output logic [8:0] PlotX,
   output logic [7:0] PlotY,
   output logic [2:0] PlotCol,
   output logic       Plot,
   output logic       Busy,
   output logic       Done,
   output logic [7:0] FrameCount
);

   localparam int            CW  = $clog2(PIPE + 1);
   localparam logic [8:0]    XL  = 9'(XMAX - 1);
   localparam logic [7:0]    YL  = 8'(YMAX - 1);
   localparam logic [CW-1:0] CLD = CW'(PIPE);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   // One delay-line slot: a coordinate in flight through the game module.
   typedef struct packed {
      logic       v;
      logic       last;
      logic [8:0] x;
      logic [7:0] y;
   } tap_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [8:0]         x_nxt;
   logic [7:0]         y_nxt;
   logic               at_end;
   logic               kill;
   logic               fire;
   tap_t [PIPE-1:0]    dl;
   tap_t               tail;

   assign at_end = (VGAx == XL) && (VGAy == YL);
   assign kill   = Abort && (state != IDLE);
   assign tail   = dl[PIPE-1];
   assign fire   = tail.v && !kill;
   assign Busy   = (state != IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = 9'd0;
      y_nxt     = 8'd0;
      unique case (state)
         IDLE: begin
            if (Start && !Abort) state_nxt = SCAN;
         end
         SCAN: begin
            if (Abort) begin
               state_nxt = IDLE;
            end else if (at_end) begin
               state_nxt = DRAIN;
               cnt_nxt   = CLD;
            end else if (VGAx == XL) begin
               y_nxt = VGAy + 8'd1;
            end else begin
               x_nxt = VGAx + 9'd1;
               y_nxt = VGAy;
            end
         end
         DRAIN: begin
            if (Abort || cnt == '0) state_nxt = IDLE;
            else cnt_nxt = cnt - CW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         VGAx  <= 9'd0;
         VGAy  <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         VGAx  <= x_nxt;
         VGAy  <= y_nxt;
      end
   end

   // The coordinate on VGAx/VGAy is live exactly while in SCAN.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         dl <= '0;
      end else begin
         dl[0] <= '{v: (state == SCAN) && !Abort,
                    last: at_end, x: VGAx, y: VGAy};
         for (int i = 1; i < PIPE; i++) begin
            dl[i] <= dl[i-1];
         end
         if (kill) begin
            for (int i = 0; i < PIPE; i++) begin
               dl[i].v <= 1'b0;
            end
         end
      end
   end

   // VGAcol is valid for the tail coordinate on this same edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Plot       <= 1'b0;
         Done       <= 1'b0;
         PlotX      <= 9'd0;
         PlotY      <= 8'd0;
         PlotCol    <= 3'd0;
         FrameCount <= 8'd0;
      end else begin
         Plot <= fire;
         Done <= fire && tail.last;
         if (fire) begin
            PlotX   <= tail.x;
            PlotY   <= tail.y;
            PlotCol <= VGAcol ? FG : BG;
         end
         if (fire && tail.last) FrameCount <= FrameCount + 8'd1;
      end
   end

endmodule
